// File: rtl/sb_param_shadow_cfg.sv
// Corner switch block (right/bottom channels) with binary-select track muxes.
// Selects arrive over a serial chain and go live only after a parity-clean frame.
module sb_param_shadow_cfg #(
   parameter int CHAN_W   = 5,
   parameter int N_PIN    = 8,
   parameter int MUX_SIZE = 4,
   parameter int SEL_W    = $clog2(MUX_SIZE)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic [CHAN_W-1:0] chanx_right_in,
   input  logic [CHAN_W-1:0] chany_bottom_in,
   input  logic [N_PIN-1:0]  right_pin_in,
   input  logic [N_PIN-1:0]  bottom_pin_in,
   input  logic              ccff_head,
   input  logic              ccff_en,
   output logic              ccff_ready,
   output logic              ccff_tail,
   output logic              cfg_done,
   output logic              cfg_err,
   output logic              cfg_valid,
   output logic [CHAN_W-1:0] chanx_right_out,
   output logic [CHAN_W-1:0] chany_bottom_out
);

   localparam int N_MUX    = 2 * CHAN_W;
   localparam int L        = 2 * CHAN_W * SEL_W + 1;
   localparam int CNT_W    = $clog2(L + 1);
   localparam int MUX_PAD  = 1 << SEL_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(L - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CHECK
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_nextCnt;
   logic [L-1:0]        r_chain;
   logic [SEL_W-1:0]    r_sel [N_MUX];
   logic                r_done;
   logic                r_err;
   logic                r_valid;
   logic                w_accept;
   logic                w_parityOk;
   logic                w_commit;
   logic                w_reject;

   assign ccff_ready = (r_state != CHECK);
   assign w_accept   = ccff_en && ccff_ready;
   assign w_parityOk = ~(^r_chain);
   assign ccff_tail  = r_chain[L-1];
   assign cfg_done   = r_done;
   assign cfg_err    = r_err;
   assign cfg_valid  = r_valid;

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_commit    = 1'b0;
      w_reject    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = SHIFT;
               w_nextCnt   = CNT_W'(1);
            end
         end
         SHIFT: begin
            if (w_accept) begin
               w_nextCnt = r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  w_nextState = CHECK;
               end
            end
         end
         CHECK: begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
            w_commit    = w_parityOk;
            w_reject    = ~w_parityOk;
         end
         default: begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
         end
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         r_chain <= '0;
      end else if (w_accept) begin
         r_chain <= {r_chain[L-2:0], ccff_head};
      end
   end

   // Active selects change only here, all at once, so routing never sees a partial frame.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_valid <= 1'b0;
         for (int j = 0; j < N_MUX; j++) begin
            r_sel[j] <= '0;
         end
      end else begin
         r_done <= w_commit;
         if (w_commit) begin
            r_valid <= 1'b1;
            r_err   <= 1'b0;
            for (int j = 0; j < N_MUX; j++) begin
               r_sel[j] <= r_chain[1 + j*SEL_W +: SEL_W];
            end
         end else if (w_reject) begin
            r_err <= 1'b1;
         end
      end
   end

   // Mux inputs are padded to a power of two with zeros, so out-of-range selects drive 0.
   for (genvar i = 0; i < CHAN_W; i++) begin : g_track
      logic [MUX_PAD-1:0] w_rightIn;
      logic [MUX_PAD-1:0] w_bottomIn;

      assign w_rightIn[0]  = chany_bottom_in[CHAN_W-1-i];
      assign w_bottomIn[0] = chanx_right_in[CHAN_W-1-i];

      for (genvar k = 1; k < MUX_SIZE; k++) begin : g_pin
         assign w_rightIn[k]  = right_pin_in[(i + (k-1)*CHAN_W) % N_PIN];
         assign w_bottomIn[k] = bottom_pin_in[(i + (k-1)*CHAN_W) % N_PIN];
      end

      for (genvar k = MUX_SIZE; k < MUX_PAD; k++) begin : g_pad
         assign w_rightIn[k]  = 1'b0;
         assign w_bottomIn[k] = 1'b0;
      end

      assign chanx_right_out[i]  = r_valid && w_rightIn[r_sel[i]];
      assign chany_bottom_out[i] = r_valid && w_bottomIn[r_sel[CHAN_W+i]];
   end

endmodule

// File: tb/tb_sb_param_shadow_cfg.sv
// Bench for sb_param_shadow_cfg: a queue-based model of the config chain and
// routing rules is compared against the DUT every cycle, plus literal spot checks.
module tb_sb_param_shadow_cfg;

   localparam int CHAN_W   = 5;
   localparam int N_PIN    = 8;
   localparam int MUX_SIZE = 4;
   localparam int SEL_W    = 2;
   localparam int NF       = 2 * CHAN_W * SEL_W;
   localparam int L        = NF + 1;

   logic              prog_clk = 1'b0;
   logic              pReset;
   logic [CHAN_W-1:0] chanx_right_in;
   logic [CHAN_W-1:0] chany_bottom_in;
   logic [N_PIN-1:0]  right_pin_in;
   logic [N_PIN-1:0]  bottom_pin_in;
   logic              ccff_head;
   logic              ccff_en;
   logic              ccff_ready;
   logic              ccff_tail;
   logic              cfg_done;
   logic              cfg_err;
   logic              cfg_valid;
   logic [CHAN_W-1:0] chanx_right_out;
   logic [CHAN_W-1:0] chany_bottom_out;

   sb_param_shadow_cfg dut (
      .prog_clk        (prog_clk),
      .pReset          (pReset),
      .chanx_right_in  (chanx_right_in),
      .chany_bottom_in (chany_bottom_in),
      .right_pin_in    (right_pin_in),
      .bottom_pin_in   (bottom_pin_in),
      .ccff_head       (ccff_head),
      .ccff_en         (ccff_en),
      .ccff_ready      (ccff_ready),
      .ccff_tail       (ccff_tail),
      .cfg_done        (cfg_done),
      .cfg_err         (cfg_err),
      .cfg_valid       (cfg_valid),
      .chanx_right_out (chanx_right_out),
      .chany_bottom_out(chany_bottom_out)
   );

   always #5 prog_clk = ~prog_clk;

   int nChecks = 0;
   int nPass   = 0;
   bit checkEn = 1'b0;

   // One comparison: counts it, and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: every accepted bit since reset is kept in a queue; chain[k] is the k-th newest.
   logic mQ[$];
   int   mCount;
   bit   mChecking, mDone, mErr, mValid;
   int   mSel [2*CHAN_W];
   int   mPar;

   function automatic logic chainBit(input int k);
      if (k < mQ.size()) return mQ[mQ.size()-1-k];
      return 1'b0;
   endfunction

   function automatic int fieldOf(input int j);
      int v = 0;
      for (int b = 0; b < SEL_W; b++) v = v | (int'(chainBit(1 + j*SEL_W + b)) << b);
      return v;
   endfunction

   function automatic logic muxOut(input int s, input logic trackIn, input logic [N_PIN-1:0] pins, input int i);
      if (s == 0) return trackIn;
      if (s < MUX_SIZE) return pins[(i + (s-1)*CHAN_W) % N_PIN];
      return 1'b0;
   endfunction

   // Model advances on the same edge the DUT does, using the inputs it sees there.
   always @(posedge prog_clk) begin
      if (pReset) begin
         mQ.delete();
         mCount    = 0;
         mChecking = 1'b0;
         mDone     = 1'b0;
         mErr      = 1'b0;
         mValid    = 1'b0;
         for (int j = 0; j < 2*CHAN_W; j++) mSel[j] = 0;
      end else begin
         mDone = 1'b0;
         if (mChecking) begin
            mPar = 0;
            for (int k = 0; k < L; k++) mPar = mPar ^ int'(chainBit(k));
            if (mPar == 0) begin
               for (int j = 0; j < 2*CHAN_W; j++) mSel[j] = fieldOf(j);
               mDone  = 1'b1;
               mValid = 1'b1;
               mErr   = 1'b0;
            end else begin
               mErr = 1'b1;
            end
            mChecking = 1'b0;
            mCount    = 0;
         end else if (ccff_en) begin
            mQ.push_back(ccff_head);
            mCount++;
            if (mCount == L) mChecking = 1'b1;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge prog_clk) begin
      logic [CHAN_W-1:0] expR;
      logic [CHAN_W-1:0] expB;
      if (checkEn) begin
         expR = '0;
         expB = '0;
         if (mValid) begin
            for (int i = 0; i < CHAN_W; i++) begin
               expR[i] = muxOut(mSel[i], chany_bottom_in[CHAN_W-1-i], right_pin_in, i);
               expB[i] = muxOut(mSel[CHAN_W+i], chanx_right_in[CHAN_W-1-i], bottom_pin_in, i);
            end
         end
         checkOutput("m_ready", 32'(ccff_ready), 32'(!mChecking));
         checkOutput("m_tail", 32'(ccff_tail), 32'(chainBit(L-1)));
         checkOutput("m_done", 32'(cfg_done), 32'(mDone));
         checkOutput("m_err", 32'(cfg_err), 32'(mErr));
         checkOutput("m_valid", 32'(cfg_valid), 32'(mValid));
         checkOutput("m_right_out", 32'(chanx_right_out), 32'(expR));
         checkOutput("m_bottom_out", 32'(chany_bottom_out), 32'(expB));
      end
   end

   function automatic logic [L-1:0] mkFrame(input logic [NF-1:0] fields);
      return {fields, ^fields};
   endfunction

   // Shifts the first nBits of a frame (chain[L-1] first), with an optional
   // ccff_en gap before bit gapAt; a full frame also walks through the CHECK cycle.
   task automatic applyStimulus(input logic [L-1:0] frame, input int nBits, input int gapAt,
                                input int gapLen, input bit holdEn);
      for (int b = 0; b < nBits; b++) begin
         if (b == gapAt) begin
            ccff_en = 1'b0;
            repeat (gapLen) begin
               @(posedge prog_clk);
               #1;
            end
         end
         ccff_en   = 1'b1;
         ccff_head = frame[L-1-b];
         @(posedge prog_clk);
         #1;
      end
      if (nBits == L) begin
         checkOutput("ready_in_check", 32'(ccff_ready), 32'd0);
         ccff_en   = holdEn;
         ccff_head = 1'b1;
         @(posedge prog_clk);
         #1;
      end
      ccff_en   = 1'b0;
      ccff_head = 1'b0;
   endtask

   logic [L-1:0] frame2;
   logic [L-1:0] frame3;
   logic [L-1:0] badFrame;

   initial begin
      frame2   = mkFrame(NF'(20'h10002));
      frame3   = mkFrame(NF'(20'h80030));
      badFrame = frame2 ^ (L'(1) << 7);

      pReset          = 1'b1;
      ccff_en         = 1'b0;
      ccff_head       = 1'b0;
      chanx_right_in  = 5'($urandom);
      chany_bottom_in = 5'($urandom);
      right_pin_in    = 8'($urandom);
      bottom_pin_in   = 8'($urandom);
      @(posedge prog_clk);
      #1;
      checkEn         = 1'b1;
      chanx_right_in  = 5'($urandom);
      right_pin_in    = 8'($urandom);
      @(posedge prog_clk);
      #1;
      checkOutput("rst_right_out", 32'(chanx_right_out), 32'd0);
      checkOutput("rst_bottom_out", 32'(chany_bottom_out), 32'd0);
      checkOutput("rst_ready", 32'(ccff_ready), 32'd1);
      checkOutput("rst_valid", 32'(cfg_valid), 32'd0);

      pReset          = 1'b0;
      chanx_right_in  = '0;
      chany_bottom_in = '0;
      right_pin_in    = '0;
      bottom_pin_in   = '0;

      $display("[TB] all-zero frame");
      applyStimulus(mkFrame('0), L, -1, 0, 1'b0);
      checkOutput("f0_done", 32'(cfg_done), 32'd1);
      checkOutput("f0_valid", 32'(cfg_valid), 32'd1);
      @(posedge prog_clk);
      #1;
      checkOutput("f0_done_once", 32'(cfg_done), 32'd0);
      chanx_right_in = 5'b10000;
      #1;
      checkOutput("f0_bottom0", 32'(chany_bottom_out), 32'h01);
      chanx_right_in  = '0;
      chany_bottom_in = 5'b10000;
      #1;
      checkOutput("f0_right0", 32'(chanx_right_out), 32'h01);
      chany_bottom_in = '0;

      $display("[TB] select routing frame");
      applyStimulus(frame2, L, -1, 0, 1'b0);
      checkOutput("f2_done", 32'(cfg_done), 32'd1);
      right_pin_in = 8'h20;
      #1;
      checkOutput("f2_right_pin5", 32'(chanx_right_out), 32'h01);
      bottom_pin_in = 8'h08;
      #1;
      checkOutput("f2_bottom_pin3", 32'(chany_bottom_out), 32'h08);
      right_pin_in  = 8'hDF;
      bottom_pin_in = 8'hF7;
      #1;
      checkOutput("f2_other_right", 32'(chanx_right_out), 32'h00);
      checkOutput("f2_other_bottom", 32'(chany_bottom_out), 32'h00);
      right_pin_in  = 8'h20;
      bottom_pin_in = 8'h00;

      $display("[TB] bad parity frame");
      applyStimulus(badFrame, L, -1, 0, 1'b0);
      checkOutput("bad_err", 32'(cfg_err), 32'd1);
      checkOutput("bad_no_done", 32'(cfg_done), 32'd0);
      checkOutput("bad_valid", 32'(cfg_valid), 32'd1);
      checkOutput("bad_routing_kept", 32'(chanx_right_out), 32'h01);
      applyStimulus(frame2, L, -1, 0, 1'b0);
      checkOutput("good_err_clr", 32'(cfg_err), 32'd0);
      checkOutput("good_done", 32'(cfg_done), 32'd1);

      $display("[TB] gap and CHECK stall");
      applyStimulus(frame3, L, 8, 3, 1'b1);
      checkOutput("f3_done", 32'(cfg_done), 32'd1);
      checkOutput("f3_tail", 32'(ccff_tail), 32'd1);
      right_pin_in  = 8'h10;
      bottom_pin_in = 8'h02;
      #1;
      checkOutput("f3_right2", 32'(chanx_right_out), 32'h04);
      checkOutput("f3_bottom4", 32'(chany_bottom_out), 32'h10);

      $display("[TB] reset mid-frame");
      applyStimulus(frame2, 10, -1, 0, 1'b0);
      pReset = 1'b1;
      @(posedge prog_clk);
      #1;
      pReset = 1'b0;
      checkOutput("mid_rst_right", 32'(chanx_right_out), 32'd0);
      checkOutput("mid_rst_bottom", 32'(chany_bottom_out), 32'd0);
      checkOutput("mid_rst_valid", 32'(cfg_valid), 32'd0);
      checkOutput("mid_rst_ready", 32'(ccff_ready), 32'd1);
      applyStimulus(frame2, L, -1, 0, 1'b0);
      checkOutput("post_rst_done", 32'(cfg_done), 32'd1);
      right_pin_in = 8'h20;
      #1;
      checkOutput("post_rst_route", 32'(chanx_right_out), 32'h01);
      applyStimulus(frame3, 12, 4, 2, 1'b0);

      repeat (4) @(posedge prog_clk);
      #1;
      checkEn = 1'b0;
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/sb_param_shadow_cfg.md
Name: sb_param_shadow_cfg

Overview:
Parametrised switch block for the generic-fpga fabric, with corner-style connectivity: right-side and bottom-side channels only. Each output track is driven by a MUX_SIZE-input mux with a binary-encoded select. Select fields load through a serial configuration chain into a shadow register and are then parity-checked. Only a clean frame is committed atomically to the active select registers, so the fabric is reconfigured glitch-free rather than bit-by-bit.

Parameters:
CHAN_W, 5, tracks per channel direction (right and bottom)
N_PIN, 8, grid pin inputs per side
MUX_SIZE, 4, inputs per track mux (>=2)
SEL_W, $clog2(MUX_SIZE), select field width per mux (derived)

Ports:
prog_clk  in  1  configuration/register clock
pReset  in  1  synchronous active-high reset
chanx_right_in  in  CHAN_W  right channel incoming tracks
chany_bottom_in  in  CHAN_W  bottom channel incoming tracks
right_pin_in  in  N_PIN  grid output pins feeding right tracks
bottom_pin_in  in  N_PIN  grid output pins feeding bottom tracks
ccff_head  in  1  serial config data
ccff_en  in  1  config bit valid
ccff_ready  out  1  block accepts a config bit this cycle
ccff_tail  out  1  chain serial out, for cascade/readback
cfg_done  out  1  one-cycle pulse on successful commit
cfg_err  out  1  sticky parity error
cfg_valid  out  1  at least one frame committed since reset
chanx_right_out  out  CHAN_W  right channel outgoing tracks
chany_bottom_out  out  CHAN_W  bottom channel outgoing tracks

Behaviour:
- Reset: one clock, prog_clk; reset pReset is synchronous, active-high. Reset clears chain, active selects, bit counter, cfg_done, cfg_err, cfg_valid and ccff_tail to 0, sets state IDLE, and holds all track outputs at 0.
- Frame length L = 2*CHAN_W*SEL_W + 1 bits (default 21).
- Chain: an accepted bit is ccff_en && ccff_ready.
  - It shifts in at chain[0]; chain[k] moves to chain[k+1].
  - ccff_tail = chain[L-1] (registered).
- Field layout after a full frame:
  - chain[0] = parity bit, the last bit shifted in.
  - chain[1+j*SEL_W +: SEL_W] = select of mux j.
  - j = 0..CHAN_W-1 are right tracks 0..CHAN_W-1.
  - j = CHAN_W..2*CHAN_W-1 are bottom tracks 0..CHAN_W-1.
- FSM:
  - IDLE: first accepted bit moves to SHIFT with cnt=1.
  - SHIFT: cnt increments per accepted bit. When the L-th bit is accepted, next state is CHECK. Gaps in ccff_en are allowed; cnt holds.
  - CHECK: lasts exactly 1 cycle; ccff_ready=0 and ccff_head is ignored.
    - Parity is ok if XOR(chain[L-1:0])==0 (even parity).
    - ok: copy all select fields to the active registers, set cfg_done=1 for one cycle, set cfg_valid=1, clear cfg_err.
    - fail: active registers unchanged, cfg_err=1.
    - Either way: cnt=0, next state IDLE.
  - ccff_ready=1 in IDLE/SHIFT.
- Mux mapping for track i:
  - Right: in[0] = chany_bottom_in[CHAN_W-1-i]. For k>=1, in[k] = right_pin_in[(i+(k-1)*CHAN_W) mod N_PIN].
  - Bottom: in[0] = chanx_right_in[CHAN_W-1-i]. For k>=1, in[k] = bottom_pin_in[(i+(k-1)*CHAN_W) mod N_PIN].
  - sel >= MUX_SIZE drives 0.
  - Data path is combinational (0-cycle latency from inputs). New selects take effect the cycle after CHECK.
- Outputs are forced 0 while cfg_valid=0.
- pReset mid-frame: the partial frame is discarded, active selects are cleared, outputs go to 0 the next cycle.
- A failed frame after a good one keeps the old routing live; cfg_valid stays 1.

Test Plan:
- Reset: assert pReset for 2 cycles with random inputs -> all outputs 0; ccff_ready=1; cfg_valid=0.
- Good frame, defaults, all selects 0, parity 0, 21 bits -> cfg_done pulses once 1 cycle after the 21st bit. Then chanx_right_in=5'b10000 gives chany_bottom_out[0]=1; chany_bottom_in[4]=1 gives chanx_right_out[0]=1.
- Select routing: right track 0 sel=2, bottom track 3 sel=1, correct parity:
  - right_pin_in[5]=1 -> chanx_right_out[0]=1.
  - bottom_pin_in[3]=1 -> chany_bottom_out[3]=1.
  - Toggling other pins -> no effect.
- Bad parity after a good frame: flip one bit -> cfg_err=1, no cfg_done, routing unchanged. A following good frame -> cfg_err=0, cfg_done pulses.
- ccff_en gaps and CHECK stall: insert 3 idle cycles mid-frame -> same result as a gapless frame. ccff_en asserted during CHECK -> bit not consumed (ccff_ready=0).
- Reset mid-frame after 10 bits -> outputs 0, cnt restarts. A full 21-bit frame then commits normally; ccff_tail reproduces ccff_head delayed 21 accepted bits.
